// File: rtl/nn_seq_pkg.sv
// Shared types for the neuron input/output sequencer.
package nn_seq_pkg;
   typedef enum logic [1:0] {LOAD, RUN, CAPTURE, OUTPUT} seq_state_t;
   localparam int COUNTER_W = 32;
endpackage

// File: rtl/sat_clamp.sv
// Combinational signed saturation from IN_MSB+1 bits down to OUT_MSB+1 bits.
module sat_clamp #(
   parameter int IN_MSB  = 15,
   parameter int OUT_MSB = 7
) (
   input  logic signed [IN_MSB:0]  in_i,
   output logic signed [OUT_MSB:0] out_o
);
   logic [IN_MSB-OUT_MSB:0] top;
   logic                    ovf;

   // Value fits only when every bit above the kept MSB matches the sign.
   assign top = in_i[IN_MSB:OUT_MSB];
   assign ovf = ~((&top) | ~(|top));

   always_comb begin
      out_o = in_i[OUT_MSB:0];
      if (ovf) out_o = in_i[IN_MSB] ? {1'b1, {OUT_MSB{1'b0}}} : {1'b0, {OUT_MSB{1'b1}}};
   end
endmodule

// File: rtl/neuron_sequencer.sv
// Loads one serial input vector, sweeps the neuron index counter, captures the result.
// Build option SEQ_SAT_OUT_EN: saturate (instead of wrap) when out_data is narrower than result_in.
module neuron_sequencer
   import nn_seq_pkg::*;
#(
   parameter int NEURON_WIDTH = 3,
   parameter int NEURON_BITS  = 7,
   parameter int COUNTER_END  = 6,
   parameter int OUT_BITS     = NEURON_BITS + 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic signed [NEURON_BITS:0] in_data,
   output logic signed [NEURON_BITS:0] data_vec [0:NEURON_WIDTH],
   output logic [COUNTER_W-1:0]        counter,
   input  logic signed [NEURON_BITS+8:0] result_in,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic signed [OUT_BITS:0]    out_data,
   output logic                        busy
);
   localparam int IDX_W = (NEURON_WIDTH > 0) ? $clog2(NEURON_WIDTH + 1) : 1;
   localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NEURON_WIDTH);
   localparam logic [COUNTER_W-1:0] CNT_END  = COUNTER_W'(COUNTER_END);

   seq_state_t                   state_q, state_d;
   logic [IDX_W-1:0]             wr_idx_q, wr_idx_d;
   logic [COUNTER_W-1:0]         cnt_q, cnt_d;
   logic signed [NEURON_BITS:0]  vec_q [0:NEURON_WIDTH];
   logic signed [NEURON_BITS:0]  vec_d [0:NEURON_WIDTH];
   logic                         ov_q, ov_d;
   logic signed [OUT_BITS:0]     od_q, od_d;
   logic signed [OUT_BITS:0]     fmt_res;

   generate
      if (OUT_BITS >= NEURON_BITS + 8) begin : g_ext
         assign fmt_res = (OUT_BITS + 1)'(result_in);
      end else begin : g_narrow
`ifdef SEQ_SAT_OUT_EN
         sat_clamp #(.IN_MSB(NEURON_BITS + 8), .OUT_MSB(OUT_BITS)) u_clamp (
            .in_i  (result_in),
            .out_o (fmt_res)
         );
`else
         assign fmt_res = result_in[OUT_BITS:0];
`endif
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= LOAD;
         wr_idx_q <= '0;
         cnt_q    <= '0;
         vec_q    <= '{default: '0};
         ov_q     <= 1'b0;
         od_q     <= '0;
      end else begin
         state_q  <= state_d;
         wr_idx_q <= wr_idx_d;
         cnt_q    <= cnt_d;
         vec_q    <= vec_d;
         ov_q     <= ov_d;
         od_q     <= od_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      wr_idx_d = wr_idx_q;
      cnt_d    = cnt_q;
      vec_d    = vec_q;
      ov_d     = ov_q;
      od_d     = od_q;
      case (state_q)
         LOAD: begin
            cnt_d = '0;
            if (in_valid) begin
               vec_d[wr_idx_q] = in_data;
               if (wr_idx_q == LAST_IDX) begin
                  wr_idx_d = '0;
                  state_d  = RUN;
               end else begin
                  wr_idx_d = wr_idx_q + 1'b1;
               end
            end
         end
         RUN: begin
            if (cnt_q == CNT_END) state_d = CAPTURE;
            else                  cnt_d   = cnt_q + 1'b1;
         end
         CAPTURE: begin
            od_d    = fmt_res;
            ov_d    = 1'b1;
            state_d = OUTPUT;
         end
         OUTPUT: begin
            // Counter stays at its end value until the result is taken.
            if (out_ready) begin
               ov_d    = 1'b0;
               cnt_d   = '0;
               state_d = LOAD;
            end
         end
         default: state_d = LOAD;
      endcase
   end

   assign in_ready  = (state_q == LOAD) && !rst;
   assign busy      = (state_q == RUN) || (state_q == CAPTURE);
   assign data_vec  = vec_q;
   assign counter   = cnt_q;
   assign out_valid = ov_q;
   assign out_data  = od_q;
endmodule

// File: tb/tb_neuron_sequencer.sv
// Scoreboard bench: wide (sign-extend) instance plus an OUT_BITS=7 narrowing instance.
module tb_neuron_sequencer;
   logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
   logic signed [7:0]  in_data = '0;
   logic signed [15:0] res_w = '0, res_n = '0;
   logic in_ready_w, in_ready_n, ov_w, ov_n, busy_w, busy_n;
   logic signed [7:0]  dv_w [0:3];
   logic signed [7:0]  dv_n [0:3];
   logic [31:0] cnt_w, cnt_n;
   logic signed [15:0] od_w;
   logic signed [7:0]  od_n;

   int total = 0, bad = 0, cyc = 0;
   int first_acc = 0, last_acc = 0, hs_cyc = 0;
   int q_w[$], q_n[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   neuron_sequencer u_w (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_data),
      .data_vec(dv_w), .counter(cnt_w), .result_in(res_w), .out_valid(ov_w),
      .out_ready(out_ready), .out_data(od_w), .busy(busy_w));

   neuron_sequencer #(.OUT_BITS(7)) u_n (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_n), .in_data(in_data),
      .data_vec(dv_n), .counter(cnt_n), .result_in(res_n), .out_valid(ov_n),
      .out_ready(out_ready), .out_data(od_n), .busy(busy_n));

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Monitor: pops the expected result whenever an output handshake is about to happen.
   always @(negedge clk) begin
      if (!rst && out_ready) begin
         if (ov_w) begin
            hs_cyc = cyc + 1;
            if (q_w.size() == 0) chk("wide_unexpected_out", od_w, 99999);
            else chk("wide_out_data", od_w, q_w.pop_front());
         end
         if (ov_n) begin
            if (q_n.size() == 0) chk("narrow_unexpected_out", od_n, 99999);
            else chk("narrow_out_data", od_n, q_n.pop_front());
         end
      end
   end

   task automatic send(input int e0, e1, e2, e3, input bit gap, input int rw, input int rn,
                       input bit push);
      int e[4];
      e = '{e0, e1, e2, e3};
      if (push) begin q_w.push_back(rw); q_n.push_back(rn); end
      for (int i = 0; i < 4; i++) begin
         int  guard;
         bit  acc;
         guard = 0; acc = 0;
         in_valid = 1; in_data = 8'(e[i]);
         while (!acc && guard < 200) begin
            acc = in_ready_w; step(); guard++;
         end
         if (!acc) chk("accept_timeout", 0, 1);
         if (i == 0) begin first_acc = cyc; res_w = 16'(rw); res_n = 16'(rn); end
         if (i < 3) chk("still_load", in_ready_w, 1);
         if (gap && i < 3) begin in_valid = 0; step(); end
      end
      in_valid = 0;
      last_acc = cyc;
   endtask

   task automatic wait_ov();
      int g;
      g = 0;
      while (!ov_w && g < 100) begin step(); g++; end
      if (!ov_w) chk("out_valid_timeout", 0, 1);
   endtask

   task automatic wait_drain();
      int g;
      g = 0;
      while ((q_w.size() != 0 || q_n.size() != 0) && g < 100) begin step(); g++; end
      chk("drain_empty", q_w.size() + q_n.size(), 0);
   endtask

   initial begin
      int a_last;
      // Reset state
      rst = 1; step(); step();
      chk("rst_in_ready", in_ready_w, 0);
      chk("rst_counter", cnt_w, 0);
      chk("rst_out_valid", ov_w, 0);
      chk("rst_out_data", od_w, 0);
      chk("rst_busy", busy_w, 0);
      chk("rst_dv0", dv_w[0], 0);
      rst = 0; step();
      chk("load_in_ready", in_ready_w, 1);

      // 1: back-to-back load, counter sweep, latency
      send(3, -2, 5, 1, 0, 42, 42, 1);
      chk("t1_dv0", dv_w[0], 3);  chk("t1_dv1", dv_w[1], -2);
      chk("t1_dv2", dv_w[2], 5);  chk("t1_dv3", dv_w[3], 1);
      chk("t1_cnt0", cnt_w, 0);   chk("t1_busy", busy_w, 1);
      for (int k = 1; k <= 6; k++) begin step(); chk("t1_counter", cnt_w, k); end
      step();  // edge t+7: capture cycle
      chk("t1_cnt_hold", cnt_w, 6);
      chk("t1_ov_early", ov_w, 0);
      step();  // edge t+8: out_valid sampled high from edge t+9
      chk("t1_ov_latency", ov_w, 1);
      chk("t1_lat_cycles", cyc + 1 - last_acc, 9);
      chk("t1_busy_out", busy_w, 0);
      out_ready = 1; step();
      chk("t1_ov_clear", ov_w, 0);
      chk("t1_cnt_clear", cnt_w, 0);
      chk("t1_back_load", in_ready_w, 1);
      out_ready = 0;

      // 2: toggled in_valid; 3: stalled output with in_valid held
      send(10, -20, 30, -40, 1, 300, `ifdef SEQ_SAT_OUT_EN 127 `else 44 `endif, 1);
      chk("t2_busy", busy_w, 1);
      chk("t2_dv0", dv_w[0], 10);  chk("t2_dv1", dv_w[1], -20);
      chk("t2_dv2", dv_w[2], 30);  chk("t2_dv3", dv_w[3], -40);
      wait_ov();
      in_valid = 1; in_data = 99;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("t3_ov_stable", ov_w, 1);
         chk("t3_od_stable", od_w, 300);
         chk("t3_in_ready", in_ready_w, 0);
         chk("t3_dv_stable", dv_w[0], 10);
      end
      in_valid = 0; out_ready = 1; step();
      chk("t3_ov_clear", ov_w, 0);

      // 6: two vectors back-to-back with out_ready tied high
      send(1, 2, 3, 4, 0, -300, `ifdef SEQ_SAT_OUT_EN -128 `else -44 `endif, 1);
      a_last = last_acc;
      send(-1, -2, -3, -4, 0, 7, 7, 1);
      chk("t6_accept_after_hs", first_acc, hs_cyc + 1);
      chk("t6_period", first_acc - a_last, 10);
      chk("t6_dv3", dv_w[3], -4);
      wait_drain();

      // 4: reset in the middle of a run
      out_ready = 0;
      send(5, 5, 5, 5, 0, 1, 1, 0);
      for (int k = 0; k < 3; k++) step();
      chk("t4_cnt3", cnt_w, 3);
      rst = 1; step();
      chk("t4_cnt", cnt_w, 0);
      chk("t4_busy", busy_w, 0);
      chk("t4_ov", ov_w, 0);
      chk("t4_dv0", dv_w[0], 0);
      chk("t4_dv3", dv_w[3], 0);
      chk("t4_in_ready_rst", in_ready_w, 0);
      rst = 0; step();
      chk("t4_in_ready", in_ready_w, 1);
      for (int k = 0; k < 10; k++) step();
      chk("t4_no_out", ov_w, 0);
      chk("t4_queue_empty", q_w.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
